// File: rtl/alu_operand_stage.sv
// Operand-fetch stage feeding the ripple ALU: 2R/1W register file with write-back
// bypass, per-register busy scoreboard and a single-entry valid/ready output register.
module alu_operand_stage #(
  parameter int unsigned DW = 32,
  parameter int unsigned AW = 5,
  parameter int unsigned CW = 4,
  parameter int unsigned IW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [AW-1:0] rs_addr,
  input  logic [AW-1:0] rt_addr,
  input  logic [AW-1:0] rd_addr,
  input  logic          rd_en,
  input  logic          use_imm,
  input  logic [IW-1:0] imm,
  input  logic [CW-1:0] alu_ctrl_in,
  input  logic          wb_en,
  input  logic [AW-1:0] wb_addr,
  input  logic [DW-1:0] wb_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] src1,
  output logic [DW-1:0] src2,
  output logic [CW-1:0] ALU_control
);

  localparam int unsigned DEPTH = 1 << AW;

  logic [DW-1:0]    regs [DEPTH];
  logic [DEPTH-1:0] busy;

  logic [DW-1:0] rs_data;
  logic [DW-1:0] rt_data;
  logic [DW-1:0] imm_ext;
  logic          wb_hit_rs;
  logic          wb_hit_rt;
  logic          haz_rs;
  logic          haz_rt;
  logic          accept;

  assign wb_hit_rs = wb_en && (wb_addr == rs_addr);
  assign wb_hit_rt = wb_en && (wb_addr == rt_addr);
  assign imm_ext   = {{(DW-IW){imm[IW-1]}}, imm};

  // Register 0 is hardwired to zero, so it neither bypasses nor hazards.
  always_comb begin
    rs_data = '0;
    rt_data = '0;
    if (rs_addr != '0) rs_data = wb_hit_rs ? wb_data : regs[rs_addr];
    if (rt_addr != '0) rt_data = wb_hit_rt ? wb_data : regs[rt_addr];
  end

  assign haz_rs   = (rs_addr != '0) && busy[rs_addr] && !wb_hit_rs;
  assign haz_rt   = (rt_addr != '0) && busy[rt_addr] && !use_imm && !wb_hit_rt;
  assign in_ready = (!out_valid || out_ready) && !haz_rs && !haz_rt;
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) regs[i] <= '0;
      busy        <= '0;
      out_valid   <= 1'b0;
      src1        <= '0;
      src2        <= '0;
      ALU_control <= '0;
    end else begin
      if (wb_en && (wb_addr != '0)) begin
        regs[wb_addr] <= wb_data;
        busy[wb_addr] <= 1'b0;
      end
      // Issued after the write-back clear so a new owner of rd keeps it busy.
      if (accept) begin
        out_valid   <= 1'b1;
        src1        <= rs_data;
        src2        <= use_imm ? imm_ext : rt_data;
        ALU_control <= alu_ctrl_in;
        if (rd_en && (rd_addr != '0)) busy[rd_addr] <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_operand_stage.sv
// Randomized bench for alu_operand_stage: a behavioural model predicts in_ready and the
// output register every cycle; directed scenarios pin key values with literals.
module tb_alu_operand_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  rs_addr, rt_addr, rd_addr, wb_addr;
  logic        rd_en, use_imm, wb_en, out_valid, out_ready;
  logic [15:0] imm;
  logic [3:0]  alu_ctrl_in, ALU_control;
  logic [31:0] wb_data, src1, src2;

  alu_operand_stage #(.DW(32), .AW(5), .CW(4), .IW(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .rs_addr(rs_addr), .rt_addr(rt_addr), .rd_addr(rd_addr), .rd_en(rd_en),
    .use_imm(use_imm), .imm(imm), .alu_ctrl_in(alu_ctrl_in),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .src1(src1), .src2(src2), .ALU_control(ALU_control)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  logic [31:0] m_reg [32];
  bit          m_busy [32];
  bit          m_valid;
  logic [31:0] m_s1, m_s2;
  logic [3:0]  m_ctrl;
  bit          started = 0;

  function automatic logic [31:0] m_read(input logic [4:0] a);
    if (a == 0) return 32'h0;
    if (wb_en && wb_addr == a) return wb_data;
    return m_reg[a];
  endfunction

  function automatic bit m_stalled(input logic [4:0] a, input bit ignore);
    if (a == 0 || ignore) return 0;
    return m_busy[a] && !(wb_en && wb_addr == a);
  endfunction

  function automatic bit m_ready();
    return (!m_valid || out_ready) && !m_stalled(rs_addr, 0) && !m_stalled(rt_addr, use_imm);
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      started <= 1;
      for (int i = 0; i < 32; i++) begin
        m_reg[i]  <= 32'h0;
        m_busy[i] <= 0;
      end
      m_valid <= 0;
      m_s1 <= 32'h0; m_s2 <= 32'h0; m_ctrl <= 4'h0;
    end else if (started) begin
      if (wb_en && wb_addr != 0) begin
        m_reg[wb_addr]  <= wb_data;
        m_busy[wb_addr] <= 0;
      end
      if (in_valid && m_ready()) begin
        m_valid <= 1;
        m_s1    <= m_read(rs_addr);
        m_s2    <= use_imm ? 32'($signed(imm)) : m_read(rt_addr);
        m_ctrl  <= alu_ctrl_in;
        if (rd_en && rd_addr != 0) m_busy[rd_addr] <= 1;
      end else if (out_ready) begin
        m_valid <= 0;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Single compare process, away from the active edge.
  always @(negedge clk) begin
    if (started) begin
      check("in_ready", 32'(in_ready), 32'(m_ready()));
      check("out_valid", 32'(out_valid), 32'(m_valid));
      if (m_valid) begin
        check("src1", src1, m_s1);
        check("src2", src2, m_s2);
        check("ALU_control", 32'(ALU_control), 32'(m_ctrl));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 0; rd_en = 0; use_imm = 0; wb_en = 0; out_ready = 1;
    rs_addr = 0; rt_addr = 0; rd_addr = 0; wb_addr = 0;
    imm = 16'h0; alu_ctrl_in = 4'h0; wb_data = 32'h0;
  endtask

  task automatic writeback(input logic [4:0] a, input logic [31:0] d);
    wb_en = 1; wb_addr = a; wb_data = d;
    tick();
    wb_en = 0;
  endtask

  initial begin
    idle();
    rst_n = 0;
    tick(); tick();
    rst_n = 1;
    check("lit_reset_valid", 32'(out_valid), 32'h0);
    check("lit_reset_src1", src1, 32'h0);
    check("lit_reset_ctrl", 32'(ALU_control), 32'h0);

    // Basic register read
    writeback(5'd1, 32'h0000_0005);
    writeback(5'd2, 32'hFFFF_FFFD);
    in_valid = 1; rs_addr = 1; rt_addr = 2; alu_ctrl_in = 4'b0010;
    tick();
    check("lit_basic_valid", 32'(out_valid), 32'h1);
    check("lit_basic_src1", src1, 32'h0000_0005);
    check("lit_basic_src2", src2, 32'hFFFF_FFFD);
    check("lit_basic_ctrl", 32'(ALU_control), 32'h2);

    // Immediate sign extension
    rs_addr = 3; use_imm = 1; imm = 16'h8000;
    tick();
    check("lit_imm_neg", src2, 32'hFFFF_8000);
    imm = 16'h7FFF;
    tick();
    check("lit_imm_pos", src2, 32'h0000_7FFF);
    use_imm = 0;

    // Busy hazard cleared by same-cycle write-back
    rs_addr = 0; rd_en = 1; rd_addr = 4;
    tick();
    rd_en = 0; rs_addr = 4;
    #1 check("lit_haz_stall", 32'(in_ready), 32'h0);
    wb_en = 1; wb_addr = 4; wb_data = 32'h1234_5678;
    #1 check("lit_haz_bypass_ready", 32'(in_ready), 32'h1);
    tick();
    check("lit_haz_bypass_src1", src1, 32'h1234_5678);
    idle();
    tick();

    // Hold under back-pressure, then back-to-back transfer
    in_valid = 1; rs_addr = 1; rt_addr = 0; out_ready = 0;
    tick();
    in_valid = 0;
    for (int i = 0; i < 3; i++) begin
      check("lit_hold_src1", src1, 32'h0000_0005);
      check("lit_hold_ready", 32'(in_ready), 32'h0);
      tick();
    end
    out_ready = 1; in_valid = 1; rs_addr = 2;
    #1 check("lit_resume_ready", 32'(in_ready), 32'h1);
    tick();
    check("lit_resume_valid", 32'(out_valid), 32'h1);
    check("lit_resume_src1", src1, 32'hFFFF_FFFD);
    idle();

    // Register 0 is never written and never busy
    writeback(5'd0, 32'hDEAD_BEEF);
    in_valid = 1; rs_addr = 0; rd_en = 1; rd_addr = 0;
    tick();
    check("lit_r0_src1", src1, 32'h0);
    rd_en = 0; rt_addr = 0;
    #1 check("lit_r0_no_stall", 32'(in_ready), 32'h1);
    tick();
    idle();

    // Reset while an entry is pending and r4 is busy
    in_valid = 1; rs_addr = 0; rd_en = 1; rd_addr = 4;
    tick();
    idle(); out_ready = 0;
    rst_n = 0;
    tick();
    rst_n = 1; out_ready = 1;
    check("lit_rst_valid", 32'(out_valid), 32'h0);
    in_valid = 1; rs_addr = 4;
    #1 check("lit_rst_ready", 32'(in_ready), 32'h1);
    tick();
    check("lit_rst_src1", src1, 32'h0);
    idle();

    // Randomized traffic over a small address range to provoke hazards
    for (int n = 0; n < 3000; n++) begin
      rst_n       = ($urandom_range(0, 199) != 0);
      in_valid    = $urandom_range(0, 3) != 0;
      rs_addr     = 5'($urandom_range(0, 7));
      rt_addr     = 5'($urandom_range(0, 7));
      rd_addr     = 5'($urandom_range(0, 7));
      rd_en       = $urandom_range(0, 1) != 0;
      use_imm     = $urandom_range(0, 3) == 0;
      imm         = 16'($urandom);
      alu_ctrl_in = 4'($urandom);
      wb_en       = $urandom_range(0, 2) == 0;
      wb_addr     = 5'($urandom_range(0, 7));
      wb_data     = $urandom;
      out_ready   = $urandom_range(0, 3) != 0;
      tick();
    end
    rst_n = 1;
    idle();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_operand_stage.md
Name: alu_operand_stage

Overview:
- Operand-fetch stage directly upstream of the 32-bit ripple ALU.
- Holds a 32x32 register file with two read ports and one write-back port, and a single-entry valid/ready output register. The output register drives the ALU's src1, src2 and ALU_control.
- A per-register busy scoreboard stalls issue while a source register awaits write-back of the ALU result.

Parameters:
- DW, 32: data width; must match ALU src width.
- AW, 5: register address width; depth is 2^AW.
- CW, 4: ALU control width.
- IW, 16: immediate width; sign-extended to DW.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset; synchronous, active-low.
- in_valid  in  1  issue request.
- in_ready  out  1  stage accepts the issue this cycle.
- rs_addr  in  AW  source-1 register.
- rt_addr  in  AW  source-2 register.
- rd_addr  in  AW  destination register to mark busy.
- rd_en  in  1  issue writes rd_addr later.
- use_imm  in  1  src2 = sign-extended imm instead of reg[rt].
- imm  in  IW  immediate.
- alu_ctrl_in  in  CW  ALU operation code, passed through.
- wb_en  in  1  write-back strobe (ALU result returning).
- wb_addr  in  AW  write-back register.
- wb_data  in  DW  write-back data.
- out_valid  out  1  src1/src2/ALU_control valid.
- out_ready  in  1  ALU side consumes the entry.
- src1  out  DW  operand 1.
- src2  out  DW  operand 2.
- ALU_control  out  CW  registered opcode.

Behaviour:
- Reset (rst_n=0 at posedge):
  - All 32 registers are set to 0 and all busy bits are cleared.
  - out_valid=0; src1, src2 and ALU_control are set to 0.
  - Reset mid-stall discards any pending entry; no write-back is performed in a reset cycle.
- Register 0 always reads 0. Writes to it are ignored, and rd_en with rd_addr=0 never sets a busy bit.
- Write-back:
  - When wb_en=1 at a posedge, reg[wb_addr] takes wb_data and busy[wb_addr] is cleared.
  - Read bypass: a same-cycle read of wb_addr (nonzero) returns wb_data.
- Hazard:
  - haz_rs = busy[rs_addr] and not (wb_en and wb_addr==rs_addr).
  - haz_rt = busy[rt_addr] and not use_imm and not (wb_en and wb_addr==rt_addr).
  - Neither hazard applies when the address is 0.
- in_ready = (!out_valid || out_ready) && !haz_rs && !haz_rt. It is combinational, and it must not depend on in_valid.
- Accept: an issue is accepted when in_valid && in_ready. On the next posedge:
  - out_valid=1.
  - src1 = bypassed reg[rs].
  - src2 = use_imm ? sign-extended imm : bypassed reg[rt].
  - ALU_control = alu_ctrl_in.
  - If rd_en and rd_addr!=0, busy[rd_addr] is set.
- Busy set and clear on the same register in the same cycle: set wins (the new issue owns it).
- Drain: if out_valid && out_ready and no accept, out_valid goes to 0. Outputs hold their last values and are don't-care.
- Hold: if out_valid && !out_ready, src1, src2 and ALU_control are stable until consumed. in_ready=0 in this case.
- Throughput and latency: full throughput is 1 issue/cycle with out_ready=1 and no hazards; latency is 1 cycle from issue to output.
- Busy bits survive stalls. A write-back to a non-busy register is legal and just updates the register.
- Immediate: bit IW-1 is replicated into bits DW-1..IW.

Test Plan:
- Reset, then write r1=0x0000_0005 and r2=0xFFFF_FFFD; issue rs=1, rt=2, ctrl=4'b0010 -> next cycle out_valid=1, src1=5, src2=0xFFFF_FFFD, ALU_control=0010.
- Issue rs=3 with use_imm=1, imm=0x8000 -> src2=0xFFFF_8000; repeat with imm=0x7FFF -> src2=0x0000_7FFF.
- Issue with rd_en=1, rd=4; next issue reads rs=4 -> in_ready=0. Assert wb_en with addr 4, data 0x1234_5678 -> in_ready=1 in the same cycle and src1=0x1234_5678 on the following cycle.
- Hold out_ready=0 for 3 cycles with an entry valid -> outputs stable, in_ready=0. Raise out_ready with in_valid=1 -> back-to-back transfer with no bubble.
- Write wb to r0 with 0xDEAD_BEEF; issue rs=0, rd_en=1, rd=0 -> src1=0, busy[0] never set, next issue not stalled.
- Assert rst_n=0 while out_valid=1 and busy[4]=1 -> next cycle out_valid=0, issue reading r4 accepted immediately with src1=0.
